// File: rtl/gcd_operand_packer.sv
// Pairs consecutive words of a val/rdy stream into registered (A,B) operands; pair valid 1 cycle after B accept.
// Backpressure: in_rdy drops only when an A word is held and the output pair is stalled (or during flush).
module gcd_operand_packer #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             in_rdy,
  input  logic             flush,
  output logic             operands_val,
  output logic [W-1:0]     operands_bits_A,
  output logic [W-1:0]     operands_bits_B,
  input  logic             operands_rdy,
  output logic [CNT_W-1:0] pair_count,
  output logic             odd_drop
);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_HOLD_A = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_out_a;
  logic [W-1:0]      r_out_b;
  logic              r_out_vld;
  logic [CNT_W-1:0]  r_pair_count;
  logic              r_odd_drop;

  logic              w_in_rdy;
  logic              w_accept;
  logic              w_out_hs;
  logic              w_load_a;
  logic              w_load_pair;
  logic              w_drop;

  // EMPTY always has room for an A word; HOLD_A needs the output slot to free up.
  assign w_in_rdy = !flush && ((r_state == ST_EMPTY) || !r_out_vld || operands_rdy);
  assign w_accept = in_val && w_in_rdy;
  assign w_out_hs = r_out_vld && operands_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_pair = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          if (in_last) begin
            w_drop = 1'b1;
          end else begin
            w_load_a    = 1'b1;
            w_state_nxt = ST_HOLD_A;
          end
        end
      end
      ST_HOLD_A: begin
        if (flush) begin
          w_drop      = 1'b1;
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          // in_last on the B word carries no meaning: the pair is complete either way.
          w_load_pair = 1'b1;
          w_state_nxt = ST_EMPTY;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
    end else if (w_load_a) begin
      r_a <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_a   <= '0;
      r_out_b   <= '0;
      r_out_vld <= 1'b0;
    end else if (w_load_pair) begin
      r_out_a   <= r_a;
      r_out_b   <= in_data;
      r_out_vld <= 1'b1;
    end else if (w_out_hs) begin
      r_out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pair_count <= '0;
      r_odd_drop   <= 1'b0;
    end else begin
      r_odd_drop <= w_drop;
      if (w_out_hs) begin
        r_pair_count <= r_pair_count + 1'b1;
      end
    end
  end

  assign in_rdy          = w_in_rdy;
  assign operands_val    = r_out_vld;
  assign operands_bits_A = r_out_a;
  assign operands_bits_B = r_out_b;
  assign pair_count      = r_pair_count;
  assign odd_drop        = r_odd_drop;

endmodule

// File: tb/tb_gcd_operand_packer.sv
// Bench for gcd_operand_packer: directed scenarios plus randomized traffic against a transaction-level model.
module tb_gcd_operand_packer;
  localparam int W     = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_val;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             in_rdy;
  logic             flush;
  logic             operands_val;
  logic [W-1:0]     operands_bits_A;
  logic [W-1:0]     operands_bits_B;
  logic             operands_rdy;
  logic [CNT_W-1:0] pair_count;
  logic             odd_drop;

  gcd_operand_packer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_data(in_data), .in_last(in_last), .in_rdy(in_rdy),
    .flush(flush),
    .operands_val(operands_val), .operands_bits_A(operands_bits_A),
    .operands_bits_B(operands_bits_B), .operands_rdy(operands_rdy),
    .pair_count(pair_count), .odd_drop(odd_drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one held word, one output pair slot, a wrapping count, a drop pulse.
  bit           m_held;
  logic [W-1:0] m_a;
  bit           m_out_vld;
  logic [W-1:0] m_A;
  logic [W-1:0] m_B;
  int           m_cnt;
  bit           m_drop;

  function automatic bit model_rdy();
    return !flush && (!m_held || !m_out_vld || operands_rdy);
  endfunction

  task automatic model_clear();
    m_held = 0; m_a = '0; m_out_vld = 0; m_A = '0; m_B = '0; m_cnt = 0; m_drop = 0;
  endtask

  task automatic set_in(input bit v, input logic [W-1:0] d, input bit l, input bit f, input bit r);
    in_val = v; in_data = d; in_last = l; flush = f; operands_rdy = r;
    #1;
  endtask

  // Advance one clock, applying the word/pair rules to the model first.
  task automatic clk_step();
    bit acc, hs, loaded;
    acc    = in_val && model_rdy();
    hs     = m_out_vld && operands_rdy;
    loaded = 0;
    m_drop = 0;
    if (flush) begin
      if (m_held) begin m_held = 0; m_drop = 1; end
    end else if (acc) begin
      if (m_held) begin
        m_A = m_a; m_B = in_data; m_held = 0; loaded = 1;
      end else if (in_last) begin
        m_drop = 1;
      end else begin
        m_held = 1; m_a = in_data;
      end
    end
    if (hs) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (loaded) m_out_vld = 1;
    else if (hs) m_out_vld = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    in_val = 0; in_data = '0; in_last = 0; flush = 0; operands_rdy = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    in_val = 0; in_data = '0; in_last = 0; flush = 0; operands_rdy = 1;
    model_clear();
    #1;
    n_vec++; if (operands_val !== 1'b0) begin n_err++; $display("FAIL reset_val: got %0b expected 0", operands_val); end
    n_vec++; if (operands_bits_A !== '0 || operands_bits_B !== '0) begin n_err++; $display("FAIL reset_bits: got A=%0d B=%0d expected 0/0", operands_bits_A, operands_bits_B); end
    n_vec++; if (pair_count !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", pair_count); end
    n_vec++; if (odd_drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %0b expected 0", odd_drop); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy: got %0b expected 1", in_rdy); end
  endtask

  task automatic test_basic_pair();
    set_in(1, 12, 0, 0, 1); clk_step();
    n_vec++; if (operands_val !== 1'b0) begin n_err++; $display("FAIL basic_val_early: got %0b expected 0", operands_val); end
    set_in(1, 18, 0, 0, 1);
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL basic_rdy: got %0b expected 1", in_rdy); end
    clk_step();
    n_vec++; if (operands_val !== 1'b1) begin n_err++; $display("FAIL basic_val: got %0b expected 1", operands_val); end
    n_vec++; if (operands_bits_A !== 32'd12 || operands_bits_B !== 32'd18) begin n_err++; $display("FAIL basic_bits: got A=%0d B=%0d expected 12/18", operands_bits_A, operands_bits_B); end
    n_vec++; if (pair_count !== 4'd0) begin n_err++; $display("FAIL basic_cnt0: got %0d expected 0", pair_count); end
    set_in(0, 0, 0, 0, 1); clk_step();
    n_vec++; if (pair_count !== 4'd1) begin n_err++; $display("FAIL basic_cnt1: got %0d expected 1", pair_count); end
    n_vec++; if (operands_val !== 1'b0) begin n_err++; $display("FAIL basic_val_after: got %0b expected 0", operands_val); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [4];
    int base;
    words = '{32'd4, 32'd6, 32'd9, 32'd15};
    base = int'(pair_count);
    for (int i = 0; i < 4; i++) begin
      set_in(1, words[i], 0, 0, 1);
      n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy%0d: got %0b expected 1", i, in_rdy); end
      clk_step();
      if (i % 2 == 1) begin
        n_vec++; if (operands_val !== 1'b1 || operands_bits_A !== words[i-1] || operands_bits_B !== words[i]) begin
          n_err++; $display("FAIL b2b_pair%0d: got val=%0b A=%0d B=%0d expected 1/%0d/%0d", i, operands_val, operands_bits_A, operands_bits_B, words[i-1], words[i]);
        end
      end else begin
        n_vec++; if (operands_val !== 1'b0) begin n_err++; $display("FAIL b2b_gap%0d: got %0b expected 0", i, operands_val); end
      end
    end
    set_in(0, 0, 0, 0, 1); clk_step();
    n_vec++; if (int'(pair_count) !== (base + 2) % 16) begin n_err++; $display("FAIL b2b_cnt: got %0d expected %0d", pair_count, (base + 2) % 16); end
  endtask

  task automatic test_backpressure();
    int base;
    base = int'(pair_count);
    set_in(1, 7, 0, 0, 0); clk_step();
    set_in(1, 21, 0, 0, 0); clk_step();
    set_in(1, 8, 0, 0, 0);
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_empty: got %0b expected 1", in_rdy); end
    clk_step();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 10, 0, 0, 0);
      n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_stall%0d: got %0b expected 0", i, in_rdy); end
      n_vec++; if (operands_val !== 1'b1 || operands_bits_A !== 32'd7 || operands_bits_B !== 32'd21) begin
        n_err++; $display("FAIL bp_hold%0d: got val=%0b A=%0d B=%0d expected 1/7/21", i, operands_val, operands_bits_A, operands_bits_B);
      end
      clk_step();
    end
    set_in(1, 10, 0, 0, 1);
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_release: got %0b expected 1", in_rdy); end
    clk_step();
    n_vec++; if (operands_val !== 1'b1 || operands_bits_A !== 32'd8 || operands_bits_B !== 32'd10) begin
      n_err++; $display("FAIL bp_new_pair: got val=%0b A=%0d B=%0d expected 1/8/10", operands_val, operands_bits_A, operands_bits_B);
    end
    n_vec++; if (int'(pair_count) !== (base + 1) % 16) begin n_err++; $display("FAIL bp_cnt1: got %0d expected %0d", pair_count, (base + 1) % 16); end
    set_in(0, 0, 0, 0, 1); clk_step();
    n_vec++; if (int'(pair_count) !== (base + 2) % 16) begin n_err++; $display("FAIL bp_cnt2: got %0d expected %0d", pair_count, (base + 2) % 16); end
  endtask

  task automatic test_odd_word();
    int base;
    base = int'(pair_count);
    set_in(1, 5, 1, 0, 1); clk_step();
    n_vec++; if (odd_drop !== 1'b1) begin n_err++; $display("FAIL odd_pulse: got %0b expected 1", odd_drop); end
    n_vec++; if (operands_val !== 1'b0) begin n_err++; $display("FAIL odd_no_pair: got %0b expected 0", operands_val); end
    set_in(1, 3, 0, 0, 1); clk_step();
    n_vec++; if (odd_drop !== 1'b0) begin n_err++; $display("FAIL odd_pulse_end: got %0b expected 0", odd_drop); end
    set_in(1, 9, 1, 0, 1); clk_step();
    n_vec++; if (operands_val !== 1'b1 || operands_bits_A !== 32'd3 || operands_bits_B !== 32'd9) begin
      n_err++; $display("FAIL odd_pair: got val=%0b A=%0d B=%0d expected 1/3/9", operands_val, operands_bits_A, operands_bits_B);
    end
    n_vec++; if (odd_drop !== 1'b0) begin n_err++; $display("FAIL odd_last_on_b: got %0b expected 0", odd_drop); end
    n_vec++; if (int'(pair_count) !== base) begin n_err++; $display("FAIL odd_cnt: got %0d expected %0d", pair_count, base); end
    set_in(0, 0, 0, 0, 1); clk_step();
  endtask

  task automatic test_flush();
    set_in(1, 11, 0, 0, 1); clk_step();
    set_in(1, 99, 0, 1, 1);
    n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL flush_rdy: got %0b expected 0", in_rdy); end
    clk_step();
    n_vec++; if (odd_drop !== 1'b1) begin n_err++; $display("FAIL flush_pulse: got %0b expected 1", odd_drop); end
    set_in(1, 2, 0, 0, 1); clk_step();
    n_vec++; if (odd_drop !== 1'b0) begin n_err++; $display("FAIL flush_pulse_end: got %0b expected 0", odd_drop); end
    n_vec++; if (operands_val !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %0b expected 0", operands_val); end
    set_in(1, 4, 0, 0, 1); clk_step();
    n_vec++; if (operands_val !== 1'b1 || operands_bits_A !== 32'd2 || operands_bits_B !== 32'd4) begin
      n_err++; $display("FAIL flush_pair: got val=%0b A=%0d B=%0d expected 1/2/4", operands_val, operands_bits_A, operands_bits_B);
    end
    set_in(0, 0, 0, 0, 1); clk_step();
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      set_in(1, 2 * i + 1, 0, 0, 1); clk_step();
      set_in(1, 2 * i + 2, 0, 0, 1); clk_step();
    end
    set_in(0, 0, 0, 0, 1); clk_step();
    n_vec++; if (pair_count !== 4'd1) begin n_err++; $display("FAIL wrap_cnt: got %0d expected 1", pair_count); end
    set_in(1, 5, 0, 0, 0); clk_step();
    set_in(1, 6, 0, 0, 0); clk_step();
    n_vec++; if (operands_val !== 1'b1) begin n_err++; $display("FAIL arst_pending: got %0b expected 1", operands_val); end
    operands_rdy = 1'b1;
    reset = 1'b0;
    #1;
    n_vec++; if (operands_val !== 1'b0) begin n_err++; $display("FAIL arst_val: got %0b expected 0", operands_val); end
    n_vec++; if (pair_count !== 4'd0) begin n_err++; $display("FAIL arst_cnt: got %0d expected 0", pair_count); end
    model_clear();
    @(posedge clk); #1;
    n_vec++; if (pair_count !== 4'd0) begin n_err++; $display("FAIL arst_no_hs: got %0d expected 0", pair_count); end
    reset = 1'b1;
    set_in(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit v, l, f, r;
    logic [W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      l = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) != 0);
      set_in(v, d, l, f, r);
      n_vec++; if (in_rdy !== model_rdy()) begin n_err++; $display("FAIL rnd_rdy@%0d: got %0b expected %0b", i, in_rdy, model_rdy()); end
      n_vec++; if (operands_val !== m_out_vld) begin n_err++; $display("FAIL rnd_val@%0d: got %0b expected %0b", i, operands_val, m_out_vld); end
      if (m_out_vld) begin
        n_vec++; if (operands_bits_A !== m_A || operands_bits_B !== m_B) begin
          n_err++; $display("FAIL rnd_bits@%0d: got A=%0h B=%0h expected %0h/%0h", i, operands_bits_A, operands_bits_B, m_A, m_B);
        end
      end
      n_vec++; if (int'(pair_count) !== m_cnt) begin n_err++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", i, pair_count, m_cnt); end
      n_vec++; if (odd_drop !== m_drop) begin n_err++; $display("FAIL rnd_drop@%0d: got %0b expected %0b", i, odd_drop, m_drop); end
      clk_step();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_val = 0; in_data = '0; in_last = 0; flush = 0; operands_rdy = 0;
    model_clear();
    test_reset();
    test_basic_pair();
    test_back_to_back();
    test_backpressure();
    test_odd_word();
    test_flush();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
